reset_sequencer: RTL and testbench

- Consumes the low-active system reset from the power-on reset generator, plus a raw push-button and a soft-reset pulse.
- Drives ordered, per-subsystem low-active resets: memory/PLL first, then VIC-II/SID, then CPU 6510.
- Before releasing the next stage, waits for each released stage's ready acknowledge, with a timeout.
- Sits between the reset generator and the C64 core subsystems in the 10 MHz fabric domain.

---
 rtl/reset_seq_pkg.sv | 30 +++
 rtl/button_debounce.sv | 59 +++++
 rtl/reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared types and helpers for the reset sequencer and its button front end.
//   seq_state_t   : sequencer FSM states
//   reset_cause_t : encoding of what started the most recent reset sequence
//   max_int       : larger of two integers (for sizing shared counters)
//   width_for     : bits needed to hold the values 0..n-1, never less than 1
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_GAP      = 2'd2,
    S_RUN      = 2'd3
  } seq_state_t;

  typedef logic [1:0] reset_cause_t;

  localparam reset_cause_t CAUSE_SYS    = 2'd0;
  localparam reset_cause_t CAUSE_BUTTON = 2'd1;
  localparam reset_cause_t CAUSE_SOFT   = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
// Two-flop synchroniser, stable-level debouncer and press-pulse generator for
// an active-low front-panel button.
//   clk         : fabric clock
//   reset       : synchronous, active-high
//   button_n    : raw button, active low, asynchronous to clk
//   pressed     : debounced level, 1 while the button is held
//   press_pulse : one-cycle pulse on the edge the debounced level becomes pressed
module button_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse
);

  localparam int CNT_W = width_for(DEBOUNCE_CYCLES);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;    // debounced raw level, 1 = released
  logic [CNT_W-1:0] cnt_reg;      // consecutive samples that disagree with level_reg
  logic             pulse_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= button_n;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg != level_reg) begin
        // This sample is the (cnt_reg+1)-th disagreeing one in a row.
        if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
          pulse_reg <= ~sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        // Any agreeing sample restarts the stability window.
        cnt_reg <= '0;
      end
    end
  end

  assign pressed     = ~level_reg;
  assign press_pulse = pulse_reg;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Releases per-subsystem active-low resets in order (stage 0 first), waiting
// for each released stage's ready acknowledge (bounded by a timeout) and a
// fixed gap before releasing the next one.
//   clk           : 10 MHz fabric clock
//   reset         : synchronous, active-high; restarts everything
//   sys_reset_n   : active-low reset from the power-on generator (synchronous)
//   but_n         : raw active-low push-button (asynchronous)
//   soft_req      : one-cycle soft-reset request
//   stage_ready   : per-stage ready; bit i only matters while waiting on stage i
//   stage_reset_n : registered active-low per-stage resets
//   all_ready     : registered, high in S_RUN
//   busy          : registered, high in every state except S_RUN
//   timeout_err   : sticky flag, set when any acknowledge times out
//   reset_cause   : what started the last sequence (sys / button / soft)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int STAGE_GAP       = 1000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int ACK_TIMEOUT     = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sys_reset_n,
  input  logic                  but_n,
  input  logic                  soft_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  all_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [1:0]            reset_cause
);

  localparam int CNT_W = width_for(max_int(STAGE_GAP, ACK_TIMEOUT));
  localparam int IDX_W = width_for(NUM_STAGES);

  logic btn_pressed;
  logic btn_pulse;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clk        (clk),
    .reset      (reset),
    .button_n   (but_n),
    .pressed    (btn_pressed),
    .press_pulse(btn_pulse)
  );

  seq_state_t              state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [NUM_STAGES-1:0]   stage_reset_n_reg;
  logic                    all_ready_reg;
  logic                    busy_reg;
  logic                    timeout_err_reg;
  reset_cause_t            reset_cause_reg;

  logic restart;
  logic ack_now;
  logic ack_expired;

  assign restart     = ~sys_reset_n | btn_pulse | soft_req;
  assign ack_now     = stage_ready[idx_reg];
  assign ack_expired = (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_HOLD;
      cnt_reg           <= '0;
      idx_reg           <= '0;
      stage_reset_n_reg <= '0;
      all_ready_reg     <= 1'b0;
      busy_reg          <= 1'b1;
      timeout_err_reg   <= 1'b0;
      reset_cause_reg   <= CAUSE_SYS;
    end else if (restart) begin
      // timeout_err deliberately survives a restart; only reset clears it.
      state_reg         <= S_HOLD;
      cnt_reg           <= '0;
      idx_reg           <= '0;
      stage_reset_n_reg <= '0;
      all_ready_reg     <= 1'b0;
      busy_reg          <= 1'b1;
      if (!sys_reset_n) begin
        reset_cause_reg <= CAUSE_SYS;
      end else if (btn_pulse) begin
        reset_cause_reg <= CAUSE_BUTTON;
      end else begin
        reset_cause_reg <= CAUSE_SOFT;
      end
    end else begin
      case (state_reg)
        S_HOLD: begin
          // The hold window only starts once the button has been let go.
          if (btn_pressed) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(STAGE_GAP - 1)) begin
            stage_reset_n_reg[0] <= 1'b1;
            cnt_reg              <= '0;
            state_reg            <= S_WAIT_ACK;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_WAIT_ACK: begin
          if (ack_now || ack_expired) begin
            // A timeout is flagged, then treated exactly like an acknowledge.
            if (!ack_now) begin
              timeout_err_reg <= 1'b1;
            end
            cnt_reg <= '0;
            if (idx_reg == IDX_W'(NUM_STAGES - 1)) begin
              state_reg     <= S_RUN;
              all_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= S_GAP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt_reg == CNT_W'(STAGE_GAP - 1)) begin
            stage_reset_n_reg[idx_reg] <= 1'b1;
            cnt_reg                    <= '0;
            state_reg                  <= S_WAIT_ACK;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_RUN: begin
          // Ready drops are ignored here; only a restart leaves S_RUN.
        end

        default: begin
          state_reg <= S_HOLD;
        end
      endcase
    end
  end

  assign stage_reset_n = stage_reset_n_reg;
  assign all_ready     = all_ready_reg;
  assign busy          = busy_reg;
  assign timeout_err   = timeout_err_reg;
  assign reset_cause   = reset_cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer with NUM_STAGES=3, STAGE_GAP=4,
// DEBOUNCE_CYCLES=8, ACK_TIMEOUT=16. Edge numbers below are counted from the
// edge that starts a sequence (first edge with reset=0, or the restart edge).
module tb_reset_sequencer;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sys_reset_n;
  logic          but_n;
  logic          soft_req;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_reset_n;
  logic          all_ready;
  logic          busy;
  logic          timeout_err;
  logic [1:0]    reset_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES     (NS),
    .STAGE_GAP      (4),
    .DEBOUNCE_CYCLES(8),
    .ACK_TIMEOUT    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sys_reset_n  (sys_reset_n),
    .but_n        (but_n),
    .soft_req     (soft_req),
    .stage_ready  (stage_ready),
    .stage_reset_n(stage_reset_n),
    .all_ready    (all_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .reset_cause  (reset_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Walk edges 1..last_e of a sequence, checking outputs after every edge
  // against hand-computed release edges r0..r2, the S_RUN edge and the edge
  // the timeout flag is expected to be set (0 = never, 1 = already set).
  task automatic track(input string tag, input int r0, input int r1, input int r2,
                       input int run_e, input int to_e, input int last_e);
    logic [NS-1:0] exp_stage;
    for (int e = 1; e <= last_e; e++) begin
      step(1);
      exp_stage = {(e >= r2), (e >= r1), (e >= r0)};
      check($sformatf("%s e%0d stage_reset_n", tag, e), 32'(stage_reset_n), 32'(exp_stage));
      check($sformatf("%s e%0d all_ready", tag, e), 32'(all_ready), 32'(e >= run_e));
      check($sformatf("%s e%0d busy", tag, e), 32'(busy), 32'(e < run_e));
      check($sformatf("%s e%0d timeout_err", tag, e), 32'(timeout_err),
            32'((to_e != 0) && (e >= to_e)));
    end
    $display("seq %s: walked %0d edges, stage_reset_n=%b all_ready=%b cause=%0d",
             tag, last_e, stage_reset_n, all_ready, reset_cause);
  endtask

  initial begin
    reset       = 1'b1;
    sys_reset_n = 1'b1;
    but_n       = 1'b1;
    soft_req    = 1'b0;
    stage_ready = 3'b111;

    // Reset state
    step(3);
    check("rst stage_reset_n", 32'(stage_reset_n), 32'h0);
    check("rst all_ready", 32'(all_ready), 32'h0);
    check("rst busy", 32'(busy), 32'h1);
    check("rst timeout_err", 32'(timeout_err), 32'h0);
    check("rst reset_cause", 32'(reset_cause), 32'h0);

    // 1: power-up with all stages ready
    reset = 1'b0;
    track("pwrup", 4, 9, 14, 15, 0, 15);
    check("pwrup cause", 32'(reset_cause), 32'h0);

    // 3: soft restart from S_RUN
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check("soft restart stage_reset_n", 32'(stage_reset_n), 32'h0);
    check("soft restart all_ready", 32'(all_ready), 32'h0);
    check("soft restart cause", 32'(reset_cause), 32'h2);
    track("soft", 4, 9, 14, 15, 0, 15);

    // 4a: 5-cycle glitch must be filtered
    but_n = 1'b0;
    step(5);
    but_n = 1'b1;
    step(20);
    check("glitch stage_reset_n", 32'(stage_reset_n), 32'h7);
    check("glitch all_ready", 32'(all_ready), 32'h1);
    check("glitch cause", 32'(reset_cause), 32'h2);
    $display("glitch: 5-cycle press, stage_reset_n=%b", stage_reset_n);

    // 4b: 30-cycle press; debounced press at +10, restart at +11
    but_n = 1'b0;
    step(10);
    check("btn pre-restart stage_reset_n", 32'(stage_reset_n), 32'h7);
    step(1);
    check("btn restart stage_reset_n", 32'(stage_reset_n), 32'h0);
    check("btn restart busy", 32'(busy), 32'h1);
    check("btn restart cause", 32'(reset_cause), 32'h1);
    step(19);
    check("btn held stage_reset_n", 32'(stage_reset_n), 32'h0);
    but_n = 1'b1;
    step(10);  // debounced release lands on this edge
    check("btn released stage_reset_n", 32'(stage_reset_n), 32'h0);
    track("button", 4, 9, 14, 15, 0, 15);
    check("btn final cause", 32'(reset_cause), 32'h1);

    // 5: sys_reset_n low during S_GAP for stage 1, soft_req in the same cycle
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    step(6);
    check("sys pre stage_reset_n", 32'(stage_reset_n), 32'h1);
    sys_reset_n = 1'b0;
    soft_req    = 1'b1;
    step(1);
    soft_req = 1'b0;
    check("sys restart stage_reset_n", 32'(stage_reset_n), 32'h0);
    check("sys restart all_ready", 32'(all_ready), 32'h0);
    check("sys restart cause", 32'(reset_cause), 32'h0);
    step(9);
    check("sys held stage_reset_n", 32'(stage_reset_n), 32'h0);
    sys_reset_n = 1'b1;
    track("sysrst", 4, 9, 14, 15, 0, 15);
    check("sys final cause", 32'(reset_cause), 32'h0);

    // 2: stage 1 never acks
    reset       = 1'b1;
    stage_ready = 3'b101;
    step(2);
    reset = 1'b0;
    track("timeout", 4, 9, 29, 30, 25, 30);
    check("timeout cause", 32'(reset_cause), 32'h0);

    // 6: soft restart keeps timeout_err; reset in S_WAIT_ACK clears it
    stage_ready = 3'b001;
    soft_req    = 1'b1;
    step(1);
    soft_req = 1'b0;
    check("sticky cause", 32'(reset_cause), 32'h2);
    check("sticky timeout_err", 32'(timeout_err), 32'h1);
    track("sticky", 4, 9, 29, 999, 1, 35);
    reset = 1'b1;
    step(1);
    check("rst2 stage_reset_n", 32'(stage_reset_n), 32'h0);
    check("rst2 timeout_err", 32'(timeout_err), 32'h0);
    check("rst2 cause", 32'(reset_cause), 32'h0);
    check("rst2 all_ready", 32'(all_ready), 32'h0);
    check("rst2 busy", 32'(busy), 32'h1);
    stage_ready = 3'b111;
    reset       = 1'b0;
    track("after_rst", 4, 9, 14, 15, 0, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
